// File: rtl/hnm_access_sequencer.sv
// hnm_access_sequencer: SSID command port sharing for the HNMPP hit-map block.
// Round-robin write/read arbitration plus a row-sweep engine (clear or dump).
//
// Ports:
//   clk, reset (async, active-low)
//   wr_req/wr_SSID/wr_grant   : write (hit-marking) requester, valid/ready
//   rd_req/rd_SSID/rd_grant   : read (lookup) requester, valid/ready
//   sweep_start/sweep_mode    : start pulse, mode 0 = clear, 1 = dump
//   sweep_busy/sweep_done     : sweep in progress / one-cycle end pulse
//   HNM_writeReady/HNM_readReady : HNMPP accept flags
//   HNM_SSID/HNM_write/HNM_read/HNM_clear : registered HNM command
//   dump_valid/dump_row       : row tag aligned with HNM read data in dump
//
// Macro HNM_SWEEP_DUMP_EN enables dump sweeps and the dump_* outputs;
// without it every sweep clears and dump_valid/dump_row are tied to 0.
module hnm_access_sequencer #(
    parameter int NROWS_HNM    = 256,
    parameter int SSID_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_req,
    input  logic [SSID_WIDTH-1:0] wr_SSID,
    output logic                  wr_grant,
    input  logic                  rd_req,
    input  logic [SSID_WIDTH-1:0] rd_SSID,
    output logic                  rd_grant,
    input  logic                  sweep_start,
    input  logic                  sweep_mode,
    output logic                  sweep_busy,
    output logic                  sweep_done,
    input  logic                  HNM_writeReady,
    input  logic                  HNM_readReady,
    output logic [SSID_WIDTH-1:0] HNM_SSID,
    output logic                  HNM_write,
    output logic                  HNM_read,
    output logic                  HNM_clear,
    output logic                  dump_valid,
    output logic [SSID_WIDTH-1:0] dump_row
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int CW = SSID_WIDTH + 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(NROWS_HNM - 1);

    state_e                state_q, state_d;
    logic                  last_rd_q, last_rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [SSID_WIDTH-1:0] ssid_q, ssid_d;
    logic                  write_q, write_d;
    logic                  read_q, read_d;
    logic                  clear_q, clear_d;
    logic                  dump_sel;
    logic                  sweep_rdy;

    assign sweep_rdy = dump_sel ? HNM_readReady : HNM_writeReady;

    always_comb begin
        state_d   = state_q;
        last_rd_d = last_rd_q;
        cnt_d     = cnt_q;
        ssid_d    = ssid_q;
        write_d   = 1'b0;
        read_d    = 1'b0;
        clear_d   = 1'b0;
        wr_grant  = 1'b0;
        rd_grant  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Grants are masked while reset is held so nothing
                // appears accepted during reset.
                wr_grant = reset & wr_req & HNM_writeReady & ~sweep_start
                         & (~rd_req | ~HNM_readReady | last_rd_q);
                rd_grant = reset & rd_req & HNM_readReady & ~sweep_start
                         & (~wr_req | ~HNM_writeReady | ~last_rd_q);
                if (sweep_start) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end else if (wr_grant) begin
                    ssid_d    = wr_SSID;
                    write_d   = 1'b1;
                    last_rd_d = 1'b0;
                end else if (rd_grant) begin
                    ssid_d    = rd_SSID;
                    read_d    = 1'b1;
                    last_rd_d = 1'b1;
                end
            end
            SWEEP: begin
                if (sweep_rdy) begin
                    ssid_d  = cnt_q[SSID_WIDTH-1:0];
                    read_d  = dump_sel;
                    write_d = ~dump_sel;
                    clear_d = ~dump_sel;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == LAST_ROW) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            last_rd_q <= 1'b1;
            cnt_q     <= '0;
            ssid_q    <= '0;
            write_q   <= 1'b0;
            read_q    <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rd_q <= last_rd_d;
            cnt_q     <= cnt_d;
            ssid_q    <= ssid_d;
            write_q   <= write_d;
            read_q    <= read_d;
            clear_q   <= clear_d;
        end
    end

    assign HNM_SSID   = ssid_q;
    assign HNM_write  = write_q;
    assign HNM_read   = read_q;
    assign HNM_clear  = clear_q;
    assign sweep_busy = (state_q != IDLE);
    assign sweep_done = (state_q == DONE);

`ifdef HNM_SWEEP_DUMP_EN
    logic                  mode_q;
    logic                  dump_iss_q;
    logic [SSID_WIDTH:0]   pipe_q [READ_LATENCY];

    // dump_iss_q marks sweep reads so requester reads never raise
    // dump_valid. It is aligned with the registered command, and the
    // pipe adds READ_LATENCY further cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q     <= 1'b0;
            dump_iss_q <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            if (state_q == IDLE && sweep_start) begin
                mode_q <= sweep_mode;
            end
            dump_iss_q <= read_d & (state_q == SWEEP);
            pipe_q[0]  <= dump_iss_q ? {1'b1, ssid_q} : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign dump_sel   = mode_q;
    assign dump_valid = pipe_q[READ_LATENCY-1][SSID_WIDTH];
    assign dump_row   = pipe_q[READ_LATENCY-1][SSID_WIDTH-1:0];
`else
    logic unused_mode;

    assign unused_mode = sweep_mode;
    assign dump_sel    = 1'b0;
    assign dump_valid  = 1'b0;
    assign dump_row    = '0;
`endif

endmodule

// File: doc/hnm_access_sequencer.md
# hnm_access_sequencer

Controller sitting directly in front of the HNMPP hit-map block, sharing its single SSID command port between a write (hit-marking) requester, a read (lookup) requester and an internal row-sweep engine. It round-robin arbitrates the two requesters, and on command sweeps every HNM row in order to clear it or, optionally, dump it. All HNM commands are registered; the HNMPP `HNM_writeReady`/`HNM_readReady` flags throttle issue.

## Interface
- `NROWS_HNM`, 256: number of HNM rows swept; must be ≤ 2^`SSID_WIDTH`.
- `SSID_WIDTH`, 8: SSID/row address width.
- `READ_LATENCY`, 2: HNM cycles from `HNM_read` issue to read data valid; range 1–8.

- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low; clears all state and outputs.
- `wr_req` in 1 / `wr_SSID` in `SSID_WIDTH` / `wr_grant` out 1: write requester, valid/ready.
- `rd_req` in 1 / `rd_SSID` in `SSID_WIDTH` / `rd_grant` out 1: read requester, valid/ready.
- `sweep_start` in 1: single-cycle pulse, starts a sweep when idle.
- `sweep_mode` in 1: sampled with `sweep_start`; 0 = clear, 1 = dump.
- `sweep_busy` out 1: sweep in progress.
- `sweep_done` out 1: one-cycle pulse at sweep end.
- `HNM_writeReady` in 1 / `HNM_readReady` in 1: HNMPP accept flags.
- `HNM_SSID` out `SSID_WIDTH`, `HNM_write` out 1, `HNM_read` out 1, `HNM_clear` out 1: registered HNM command.
- `dump_valid` out 1 / `dump_row` out `SSID_WIDTH`: row tag aligned with HNM read data during dump.

## Operation
- FSM states: IDLE, SWEEP, DONE. Reset → IDLE.
- IDLE grants (combinational): `wr_grant` = `wr_req` & `HNM_writeReady` & ~`sweep_start` & (~`rd_req` | ~`HNM_readReady` | `last_rd`). `rd_grant` is symmetric with `last_rd` inverted. At most one grant per cycle.
- Transfer occurs on the edge where req & grant; the command is registered: `HNM_SSID` ← requester SSID, `HNM_write` or `HNM_read` = 1 for one cycle. `last_rd` updates to the served side. Reset value of `last_rd` = 1, so the write side wins the first tie.
- `sweep_start` in IDLE has priority over both requests: no grant that cycle. Latch mode, row counter ← 0, → SWEEP. `sweep_start` outside IDLE is ignored.
- SWEEP: grants held 0. Each cycle the relevant ready is high (`HNM_writeReady` for clear, `HNM_readReady` for dump), issue row = counter: clear → `HNM_clear`=1 with `HNM_write`=1; dump → `HNM_read`=1. Counter +1. When not ready, stall, holding the counter, with command strobes 0.
- After row `NROWS_HNM`-1 is issued → DONE: `sweep_done`=1 for one cycle → IDLE. Counter width is `SSID_WIDTH`+1, with no wrap.
- Dump: each issued read pushes {1, row} into a `READ_LATENCY`-deep shift register, whose output drives `dump_valid`/`dump_row`. The shift register drains after DONE; requests granted after the sweep do not set `dump_valid`.
- Asserting `reset` mid-sweep aborts the sweep immediately: no `sweep_done`, shift register flushed, state IDLE.

## Timing
- Reset values: all outputs 0; `HNM_SSID` = 0; `sweep_busy` = 0.
- Request latency: the command appears on the HNM port 1 cycle after the transfer edge.
- Streaming: one command per cycle while req and ready hold; alternating when both requesters are active.
- `sweep_busy` goes high on the edge after `sweep_start` and stays high through the DONE cycle.
- Unstalled sweep: `NROWS_HNM` command cycles, plus 1 DONE cycle.
- Each row's `dump_valid` comes exactly `READ_LATENCY` cycles after its `HNM_read`.

## Configuration
- `HNM_SWEEP_DUMP_EN` defined: dump mode, the shift register and the `dump_valid`/`dump_row` outputs are live.
- Not defined: `sweep_mode` is ignored (every sweep clears), the shift register is not built, and `dump_valid`/`dump_row` are tied to 0.

## Test plan
- Reset 0 with both requests high → all outputs 0; release, `wr_req`=1 SSID 0x12 with ready → `HNM_write`=1, `HNM_SSID`=0x12 next cycle.
- `wr_req` and `rd_req` both held for 4 cycles, both ready → issue order W,R,W,R; grants alternate.
- `sweep_start` with `sweep_mode`=0, NROWS_HNM=256, `HNM_writeReady` low on rows 5–7 → 256 clear commands, rows 0..255 in order, no repeats; `sweep_done` after row 255.
- Dump sweep (macro on), READ_LATENCY=2 → `dump_row`=N valid 2 cycles after `HNM_read` of row N.
- `sweep_start` and `wr_req` in the same cycle → no grant; write served only after `sweep_done`.
- Reset at row 100 → outputs 0 at once, no `sweep_done`, next sweep starts at row 0.
